// File: rtl/sonic_rx_ring_ctl.sv
// sonic_rx_ring_ctl: RX ring controller packing IN_WIDTH words into OUT_WIDTH owords stored in a DEPTH-oword ring.
//   Ports: clk_in/reset (sync, active-high); enable_sfp (0 = hold ring clear);
//   wr_valid/wr_data input words (bit 0 earliest); rd_req/rd_address -> rd_data/rd_valid host read;
//   rptr_wr/rptr_in host read pointer update (rptr_err on illegal value); blk_size/blk_evt block event;
//   rx_ring_wptr/rx_used/rx_full/rx_empty ring status; drop_cnt/drop_clr overflow drop counter;
//   flush partial-oword flush, active only when SONIC_RX_PARTIAL_FLUSH_EN is defined.
module sonic_rx_ring_ctl #(
    parameter int IN_WIDTH  = 40,
    parameter int OUT_WIDTH = 128,
    parameter int DEPTH     = 512,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable_sfp,
    input  logic                 wr_valid,
    input  logic [IN_WIDTH-1:0]  wr_data,
    input  logic                 rd_req,
    input  logic [AW-1:0]        rd_address,
    output logic [OUT_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rptr_wr,
    input  logic [AW:0]          rptr_in,
    input  logic [AW:0]          blk_size,
    output logic [AW:0]          rx_ring_wptr,
    output logic [AW:0]          rx_used,
    output logic                 rx_full,
    output logic                 rx_empty,
    output logic [31:0]          drop_cnt,
    input  logic                 drop_clr,
    output logic                 blk_evt,
    output logic                 rptr_err,
    input  logic                 flush
);
    localparam int PW    = AW + 1;
    localparam int ACC_W = OUT_WIDTH + IN_WIDTH;
    localparam int FW    = $clog2(ACC_W);

    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [ACC_W-1:0]     acc_q, acc_d, acc_ins;
    logic [FW-1:0]        fill_q, fill_d, fill_ins;
    logic [OUT_WIDTH-1:0] ow_q, rd_data_q;
    logic                 ow_vld_q, ow_vld_d, emit;
    logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d, evt_ptr_q, evt_ptr_d, used;
    logic                 full, live, wr_en, rptr_ok, evt_hit;
    logic [31:0]          drop_cnt_q, drop_cnt_d;
    logic                 rd_valid_q, blk_evt_q, rptr_err_q;

    // Gearbox: bits above fill are always zero, so OR-in is a safe append and a
    // flushed partial oword comes out already zero-padded.
    always_comb begin
        acc_ins  = wr_valid ? acc_q | ({{OUT_WIDTH{1'b0}}, wr_data} << fill_q) : acc_q;
        fill_ins = wr_valid ? fill_q + FW'(IN_WIDTH) : fill_q;
        emit     = fill_ins >= FW'(OUT_WIDTH);
        acc_d    = emit ? acc_ins >> OUT_WIDTH : acc_ins;
        fill_d   = emit ? fill_ins - FW'(OUT_WIDTH) : fill_ins;
        ow_vld_d = emit;
`ifdef SONIC_RX_PARTIAL_FLUSH_EN
        // A full oword takes precedence; flush then applies on a later cycle.
        if (flush && !emit && fill_ins != '0) begin
            ow_vld_d = 1'b1;
            acc_d    = '0;
            fill_d   = '0;
        end
`endif
    end

`ifndef SONIC_RX_PARTIAL_FLUSH_EN
    logic unused_flush;
    assign unused_flush = flush;
`endif

    // Full/drop and rptr legality are judged on pre-edge pointers.
    always_comb begin
        used       = wptr_q - rptr_q;
        full       = used == PW'(DEPTH);
        live       = ow_vld_q && enable_sfp && !reset;
        wr_en      = live && !full;
        wptr_d     = wptr_q + PW'(wr_en);
        rptr_ok    = (wptr_q - rptr_in) <= PW'(DEPTH);
        rptr_d     = (rptr_wr && rptr_ok) ? rptr_in : rptr_q;
        evt_hit    = blk_size != '0 && (wptr_q - evt_ptr_q) >= blk_size;
        evt_ptr_d  = evt_hit ? evt_ptr_q + blk_size : evt_ptr_q;
        drop_cnt_d = drop_clr ? '0 : (live && full && ~&drop_cnt_q) ? drop_cnt_q + 32'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk_in) begin
        if (reset || !enable_sfp) begin
            acc_q      <= '0;
            fill_q     <= '0;
            ow_vld_q   <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            evt_ptr_q  <= '0;
            rd_valid_q <= 1'b0;
            blk_evt_q  <= 1'b0;
            rptr_err_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            ow_vld_q   <= ow_vld_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            evt_ptr_q  <= evt_ptr_d;
            rd_valid_q <= rd_req;
            blk_evt_q  <= evt_hit;
            rptr_err_q <= rptr_wr && !rptr_ok;
        end
    end

    // Drop counter and read data survive enable_sfp=0; only reset clears them.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            drop_cnt_q <= '0;
            rd_data_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            if (rd_req && enable_sfp) rd_data_q <= mem[rd_address];
        end
    end

    always_ff @(posedge clk_in) begin
        ow_q <= acc_ins[OUT_WIDTH-1:0];
        if (wr_en) mem[wptr_q[AW-1:0]] <= ow_q;
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign rx_ring_wptr = wptr_q;
    assign rx_used      = used;
    assign rx_full      = full;
    assign rx_empty     = used == '0;
    assign drop_cnt     = drop_cnt_q;
    assign blk_evt      = blk_evt_q;
    assign rptr_err     = rptr_err_q;
endmodule
